seq_borrow_sub: RTL and testbench

//   Multi-cycle borrow-lookahead subtractor: d = a - b - bin over N_BIT bits, processed

---
 rtl/seq_borrow_sub.sv | 151 +++++++++++++++
 tb/tb_seq_borrow_sub.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/seq_borrow_sub.sv
// seq_borrow_sub: multi-cycle borrow-lookahead subtractor, d = a - b - bin.
// Resolves CHUNK bits per BUSY cycle from the LSB, with the borrow carried between
// chunks in a register; valid/ready handshake on both sides.
// Optional feature: define BORROW_SAT_EN to clamp d to 0 (and raise sat) when the
// final borrow is set; otherwise d wraps modulo 2^N_BIT and sat stays 0.
module seq_borrow_sub #(
   parameter int unsigned N_BIT = 16,
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N_BIT-1:0] a,
   input  logic [N_BIT-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N_BIT-1:0] d,
   output logic             bout,
   output logic             sat
);

   localparam int unsigned N_CHUNK = N_BIT / CHUNK;
   localparam int unsigned IDX_W   = $clog2(N_CHUNK + 1);

   // Operand width must be a whole number of chunks.
   if ((N_BIT % CHUNK) != 0) begin : g_bad_chunk
      $error("seq_borrow_sub: N_BIT must be a multiple of CHUNK");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_n;
   logic [N_BIT-1:0]   a_q, a_n;
   logic [N_BIT-1:0]   b_q, b_n;
   logic               brw_q, brw_n;
   logic [IDX_W-1:0]   idx_q, idx_n;
   logic [N_BIT-1:0]   d_n;
   logic               bout_n;
   logic               sat_n;
   logic               in_ready_n;
   logic               out_valid_n;

   // Chunk datapath signals
   int                 lo;
   logic [CHUNK-1:0]   ca, cb, cg, cp, cd;
   logic [CHUNK:0]     cc;

   // Borrow lookahead across the chunk currently selected by idx.
   always_comb begin : p_chunk
      lo = (idx_q < IDX_W'(N_CHUNK)) ? int'(idx_q) * int'(CHUNK) : 0;
      ca = a_q[lo +: CHUNK];
      cb = b_q[lo +: CHUNK];
      cg = '0;
      cp = '0;
      cd = '0;
      cc = '0;
      cc[0] = brw_q;
      for (int i = 0; i < int'(CHUNK); i++) begin
         cg[i]   = ~ca[i] & cb[i];
         cp[i]   = ~(ca[i] ^ cb[i]);
         cc[i+1] = cg[i] | (cp[i] & cc[i]);
         cd[i]   = ca[i] ^ cb[i] ^ cc[i];
      end
   end

   // Next-state and next-output logic.
   always_comb begin : p_next
      state_n = state_q;
      a_n     = a_q;
      b_n     = b_q;
      brw_n   = brw_q;
      idx_n   = idx_q;
      d_n     = d;
      bout_n  = bout;
      sat_n   = sat;
      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               state_n = S_BUSY;
               a_n     = a;
               b_n     = b;
               brw_n   = bin;
               idx_n   = '0;
               sat_n   = 1'b0;
            end
         end
         S_BUSY: begin
            // idx == N_CHUNK is the finalize cycle: all chunks resolved, latch flags.
            if (idx_q == IDX_W'(N_CHUNK)) begin
               state_n = S_DONE;
               bout_n  = brw_q;
               sat_n   = 1'b0;
`ifdef BORROW_SAT_EN
               if (brw_q) begin
                  d_n   = '0;
                  sat_n = 1'b1;
               end
`endif
            end else begin
               d_n[lo +: CHUNK] = cd;
               brw_n            = cc[CHUNK];
               idx_n            = idx_q + IDX_W'(1);
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_n = S_IDLE;
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
      in_ready_n  = (state_n == S_IDLE);
      out_valid_n = (state_n == S_DONE);
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin : p_regs
      if (!rst_n) begin
         state_q   <= S_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         brw_q     <= 1'b0;
         idx_q     <= '0;
         d         <= '0;
         bout      <= 1'b0;
         sat       <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         state_q   <= state_n;
         a_q       <= a_n;
         b_q       <= b_n;
         brw_q     <= brw_n;
         idx_q     <= idx_n;
         d         <= d_n;
         bout      <= bout_n;
         sat       <= sat_n;
         in_ready  <= in_ready_n;
         out_valid <= out_valid_n;
      end
   end

endmodule

// File: tb/tb_seq_borrow_sub.sv
// tb_seq_borrow_sub: directed and random checks of seq_borrow_sub (N_BIT=16, CHUNK=4).
module tb_seq_borrow_sub;

`ifdef BORROW_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        bin;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] d;
   logic        bout;
   logic        sat;

   int tests;
   int errors;

   seq_borrow_sub #(.N_BIT(16), .CHUNK(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .d         (d),
      .bout      (bout),
      .sat       (sat)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One full transaction; checks handshake, latency and result.
   task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb2,
                         input logic tbin, input logic [15:0] ed, input logic eb);
      int n;
      logic [15:0] ed2;
      logic        es;
      ed2 = (SAT_EN && eb) ? 16'h0000 : ed;
      es  = SAT_EN && eb;
      @(negedge clk);
      check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
      a = ta; b = tb2; bin = tbin; in_valid = 1'b1;
      @(posedge clk); #1;
      check({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, " latency"}, 32'(n), 32'd5);
      check({tag, " d"}, 32'(d), 32'(ed2));
      check({tag, " bout"}, 32'(bout), 32'(eb));
      check({tag, " sat"}, 32'(sat), 32'(es));
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
      check({tag, " in_ready back"}, 32'(in_ready), 32'd1);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      logic [15:0] hd;
      logic        hb;
      logic [16:0] m;
      int          n;
      tests = 0; errors = 0;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; bin = 1'b0;
      #12;
      check("reset in_ready", 32'(in_ready), 32'd1);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset d", 32'(d), 32'd0);
      check("reset bout", 32'(bout), 32'd0);
      check("reset sat", 32'(sat), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("t1", 16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0);
      run_op("t2", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1);
      run_op("t3", 16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0);

      // Back-pressure in DONE: outputs hold, no new accept.
      @(negedge clk);
      a = 16'h0500; b = 16'h0203; bin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      a = 16'hAAAA; b = 16'h1111; bin = 1'b1;
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("t4 latency", 32'(n), 32'd5);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check("t4 hold out_valid", 32'(out_valid), 32'd1);
         check("t4 hold d", 32'(d), 32'h02FD);
         check("t4 hold bout", 32'(bout), 32'd0);
         check("t4 hold in_ready", 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("t4 in_ready after", 32'(in_ready), 32'd1);
      check("t4 out_valid after", 32'(out_valid), 32'd0);
      @(negedge clk);
      out_ready = 1'b0;
      @(posedge clk); #1;
      check("t4 no stray accept", 32'(in_ready), 32'd1);

      // Reset during BUSY chunk 2.
      @(negedge clk);
      a = 16'h4321; b = 16'h1234; bin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("t5 rst out_valid", 32'(out_valid), 32'd0);
      check("t5 rst in_ready", 32'(in_ready), 32'd1);
      check("t5 rst d", 32'(d), 32'd0);
      #2;
      rst_n = 1'b1;
      run_op("t5", 16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0);

      run_op("t6", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);

      // Random operations against (a - b - bin) mod 2^16.
      for (int k = 0; k < 1000; k++) begin
         logic [15:0] ra, rb;
         logic        rbin;
         ra   = 16'($urandom);
         rb   = 16'($urandom);
         rbin = 1'($urandom_range(0, 1));
         m    = {1'b0, ra} - {1'b0, rb} - {16'd0, rbin};
         hd   = m[15:0];
         hb   = m[16];
         run_op("rand", ra, rb, rbin, hd, hb);
      end

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
